// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the E stage and the
// multi-cycle divider. The pipeline side uses the master modport, the
// divider uses the slave modport.
interface div_unit_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        ready_o;
    logic        busy_o;
    logic        stall_o;

    modport master (
        output start_i, signed_i, a_i, b_i, cancel_i,
        input  hi_o, lo_o, ready_o, busy_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, cancel_i,
        output hi_o, lo_o, ready_o, busy_o, stall_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit restoring divider for DIV/DIVU, one quotient bit per
// cycle. HI receives the remainder, LO the quotient. 33 cycles from the
// accepted start to the ready pulse; stall_o holds the front of the pipe.
// Build option: define DIV_SIGNED_EN to build the signed (DIV) path; without
// it signed_i is ignored and every operation is DIVU.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic [63:0] remQuo_r;
    logic [63:0] remQuoNext_s;
    logic [31:0] divisor_r;
    logic [31:0] dividendOrig_r;
    logic        divZero_r;
    logic [4:0]  count_r;
    logic [32:0] trial_s;
    logic [31:0] opA_s;
    logic [31:0] opB_s;
    logic [31:0] quoRes_s;
    logic [31:0] remRes_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        ready_r;
    logic        busy_r;

`ifdef DIV_SIGNED_EN
    logic quoNeg_r;
    logic remNeg_r;
    logic quoNegIn_s;
    logic remNegIn_s;

    // Two's-complement negate when neg is set; |0x80000000| stays 0x80000000.
    function automatic logic [31:0] condNeg(input logic [31:0] v, input logic neg);
        if (neg) begin
            condNeg = 32'd0 - v;
        end else begin
            condNeg = v;
        end
    endfunction

    // Operand magnitudes and result signs captured at start.
    always_comb begin
        quoNegIn_s = bus.signed_i & (bus.a_i[31] ^ bus.b_i[31]);
        remNegIn_s = bus.signed_i & bus.a_i[31];
        opA_s      = condNeg(bus.a_i, remNegIn_s);
        opB_s      = condNeg(bus.b_i, bus.signed_i & bus.b_i[31]);
    end
`else
    logic unusedSigned_s;
    assign unusedSigned_s = bus.signed_i;

    // Unsigned-only build: operands pass through untouched.
    always_comb begin
        opA_s = bus.a_i;
        opB_s = bus.b_i;
    end
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract on 33 bits.
    always_comb begin
        trial_s = remQuo_r[63:31] - {1'b0, divisor_r};
        if (!trial_s[32]) begin
            remQuoNext_s = {trial_s[31:0], remQuo_r[30:0], 1'b1};
        end else begin
            remQuoNext_s = {remQuo_r[62:0], 1'b0};
        end
    end

    // Final HI/LO values, written on the transition into DONE.
    always_comb begin
        if (divZero_r) begin
            quoRes_s = 32'hFFFF_FFFF;
            remRes_s = dividendOrig_r;
        end else begin
`ifdef DIV_SIGNED_EN
            quoRes_s = condNeg(remQuoNext_s[31:0], quoNeg_r);
            remRes_s = condNeg(remQuoNext_s[63:32], remNeg_r);
`else
            quoRes_s = remQuoNext_s[31:0];
            remRes_s = remQuoNext_s[63:32];
`endif
        end
    end

    // Next-state logic; cancel forces IDLE from any state.
    always_comb begin
        nextState_s = state_r;
        if (bus.cancel_i) begin
            nextState_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    nextState_s = bus.start_i ? DIV : IDLE;
                DIV:     nextState_s = (count_r == 5'd31) ? DONE : DIV;
                DONE:    nextState_s = IDLE;
                default: nextState_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Working registers: operand latch in IDLE, one iteration per DIV cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remQuo_r       <= 64'd0;
            divisor_r      <= 32'd0;
            dividendOrig_r <= 32'd0;
            divZero_r      <= 1'b0;
            count_r        <= 5'd0;
`ifdef DIV_SIGNED_EN
            quoNeg_r       <= 1'b0;
            remNeg_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (nextState_s == DIV) begin
                        remQuo_r       <= {32'd0, opA_s};
                        divisor_r      <= opB_s;
                        dividendOrig_r <= bus.a_i;
                        divZero_r      <= (bus.b_i == 32'd0);
                        count_r        <= 5'd0;
`ifdef DIV_SIGNED_EN
                        quoNeg_r       <= quoNegIn_s;
                        remNeg_r       <= remNegIn_s;
`endif
                    end
                end
                DIV: begin
                    remQuo_r <= remQuoNext_s;
                    count_r  <= count_r + 5'd1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Registered outputs; HI/LO only change when a result completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= (nextState_s == DONE);
            busy_r  <= (nextState_s == DIV);
            if ((state_r == DIV) && (nextState_s == DONE)) begin
                hi_r <= remRes_s;
                lo_r <= quoRes_s;
            end
        end
    end

    assign bus.hi_o    = hi_r;
    assign bus.lo_o    = lo_r;
    assign bus.ready_o = ready_r;
    assign bus.busy_o  = busy_r;
    assign bus.stall_o = bus.start_i & ~bus.cancel_i & (state_r != DONE);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random divides checked against an arithmetic
// reference model (plain / and % on the operands).
module tb_div_unit;
`ifdef DIV_SIGNED_EN
    localparam bit SignedBuild = 1'b1;
`else
    localparam bit SignedBuild = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_if dif();
    div_unit u_dut (.clk(clk), .rst(rst), .bus(dif.slave));

    int vecCnt = 0;
    int errCnt = 0;
    logic [31:0] lastLo = 32'd0;
    logic [31:0] lastHi = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics with the divide-by-zero convention.
    task automatic refDiv(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && SignedBuild) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = 32'(lq);
            r  = 32'(lr);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] b, input bit s);
        dif.start_i  = 1'b1;
        dif.signed_i = s;
        dif.a_i      = a;
        dif.b_i      = b;
        dif.cancel_i = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input bit s);
        @(negedge clk);
        present(a, b, s);
        #1;
        chk({tag, "_stall_start"}, 32'(dif.stall_o), 32'd1);
    endtask

    // Counts cycles until ready_o, then checks latency, results and handshake.
    task automatic waitReady(input string tag, input int expLat, input logic [31:0] expLo,
                             input logic [31:0] expHi, input bit dropStart);
        int cyc = 0;
        int busyN = 0;
        int stallN = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= expLat + 6 && !seen; i++) begin
            @(negedge clk);
            cyc = i;
            if (dif.ready_o) begin
                seen = 1'b1;
            end else begin
                if (dif.busy_o) busyN++;
                if (dif.stall_o) stallN++;
            end
        end
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(expLat));
        chk({tag, "_lo"}, dif.lo_o, expLo);
        chk({tag, "_hi"}, dif.hi_o, expHi);
        chk({tag, "_stall_ready"}, 32'(dif.stall_o), 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busyN), 32'd32);
        chk({tag, "_stall_cycles"}, 32'(stallN), 32'(expLat - 1));
        lastLo = expLo;
        lastHi = expHi;
        if (dropStart) dif.start_i = 1'b0;
    endtask

    task automatic countReady(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dif.ready_o) pulses++;
        end
        chk({tag, "_no_ready"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        bit s;

        dif.start_i = 1'b0; dif.signed_i = 1'b0; dif.cancel_i = 1'b0;
        dif.a_i = 32'd0; dif.b_i = 32'd0;

        // Reset values and stall following start_i during reset.
        #2 rst = 1'b0;
        #1;
        chk("rst_hi", dif.hi_o, 32'd0);
        chk("rst_lo", dif.lo_o, 32'd0);
        chk("rst_ready", 32'(dif.ready_o), 32'd0);
        chk("rst_busy", 32'(dif.busy_o), 32'd0);
        dif.start_i = 1'b1;
        #1 chk("rst_stall_hi", 32'(dif.stall_o), 32'd1);
        dif.start_i = 1'b0;
        #1 chk("rst_stall_lo", 32'(dif.stall_o), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Divide by zero in both modes.
        issue("dz_u", 32'h1234_5678, 32'd0, 1'b0);
        waitReady("dz_u", 33, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        issue("dz_s", 32'h1234_5678, 32'd0, 1'b1);
        waitReady("dz_s", 33, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Reset in the middle of a division.
        issue("rstmid", 32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        dif.start_i = 1'b0;
        #1;
        chk("rstmid_hi", dif.hi_o, 32'd0);
        chk("rstmid_lo", dif.lo_o, 32'd0);
        chk("rstmid_busy", 32'(dif.busy_o), 32'd0);
        chk("rstmid_ready", 32'(dif.ready_o), 32'd0);
        @(negedge clk) rst = 1'b1;
        countReady("rstmid", 40);
        issue("u100_7", 32'd100, 32'd7, 1'b0);
        waitReady("u100_7", 33, 32'd14, 32'd2, 1'b1);

        // Signed and unsigned interpretation of the same operands.
        issue("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
`ifdef DIV_SIGNED_EN
        waitReady("s_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
`else
        waitReady("s_m7_2", 33, 32'h7FFF_FFFC, 32'd1, 1'b1);
`endif
        issue("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        waitReady("u_m7_2", 33, 32'h7FFF_FFFC, 32'd1, 1'b1);

        // Most-negative / -1.
        issue("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`ifdef DIV_SIGNED_EN
        waitReady("ovf", 33, 32'h8000_0000, 32'd0, 1'b1);
`else
        waitReady("ovf", 33, 32'd0, 32'h8000_0000, 1'b1);
`endif

        // Cancel at cycle 5: no result, outputs hold the previous value.
        issue("cancel", 32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        dif.cancel_i = 1'b1;
        @(negedge clk);
        chk("cancel_busy", 32'(dif.busy_o), 32'd0);
        chk("cancel_stall", 32'(dif.stall_o), 32'd0);
        chk("cancel_ready", 32'(dif.ready_o), 32'd0);
        chk("cancel_hi", dif.hi_o, lastHi);
        chk("cancel_lo", dif.lo_o, lastLo);
        dif.start_i = 1'b0;
        dif.cancel_i = 1'b0;
        countReady("cancel", 40);
        chk("cancel_hold_hi", dif.hi_o, lastHi);
        chk("cancel_hold_lo", dif.lo_o, lastLo);

        // Start together with cancel in IDLE is ignored.
        @(negedge clk);
        dif.start_i = 1'b1;
        dif.cancel_i = 1'b1;
        @(negedge clk);
        chk("stcan_busy", 32'(dif.busy_o), 32'd0);
        chk("stcan_stall", 32'(dif.stall_o), 32'd0);
        dif.start_i = 1'b0;
        dif.cancel_i = 1'b0;

        // Back-to-back: start held through ready, new operands after it.
        issue("b2b_1", 32'd1000, 32'd9, 1'b0);
        waitReady("b2b_1", 33, 32'd111, 32'd1, 1'b0);
        present(32'hFFFF_FF00, 32'd16, 1'b1);
        refDiv(32'hFFFF_FF00, 32'd16, 1'b1, q, r);
        waitReady("b2b_2", 34, q, r, 1'b0);
        present(32'd77, 32'd0, 1'b0);
        waitReady("b2b_3", 34, 32'hFFFF_FFFF, 32'd77, 1'b1);

        // Random operands against the reference model.
        for (int n = 0; n < 14; n++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            refDiv(a, b, s, q, r);
            issue($sformatf("rnd%0d", n), a, b, s);
            waitReady($sformatf("rnd%0d", n), 33, q, r, 1'b1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
